stack_cmd_frontend: RTL and testbench

Front-end stage directly upstream of the LIFO/FIFO stack memory. Turns raw, bouncy push/pop switch inputs into clean, single-shot push/pop commands with a captured data byte. Presents them to the stack over a valid/ready handshake and tracks stack occupancy, so illegal push-when-full and pop-when-empty commands never reach the stack.

---
 rtl/stack_cmd_frontend.sv | 191 +++++++++++++++++++
 tb/tb_stack_cmd_frontend.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_cmd_frontend.sv
// stack_cmd_frontend
//   Turns bouncy push/pop switch inputs into clean single-shot commands for
//   the stack memory. It also tracks how many entries have been issued, so a
//   push when full or a pop when empty never reaches the stack.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   btn_push_raw/pop_raw  raw asynchronous switch inputs
//   data_in               push data byte, captured on the edge a push loads
//   err_clear             synchronous clear of the sticky error flags
//   cmd_valid/push/pop    command register, presented over valid/ready
//   cmd_data              byte captured for a push (0 for a pop)
//   cmd_ready             stack accepts the command this cycle
//   level, full, empty    issued-entry accounting
//   err_overflow          sticky: push rejected because the stack was full
//   err_underflow         sticky: pop rejected because the stack was empty
//   err_dropped           sticky: event lost (register busy or push+pop together)
module stack_cmd_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEPTH           = 256,
  parameter int LEVEL_W         = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_push_raw,
  input  logic               btn_pop_raw,
  input  logic [7:0]         data_in,
  input  logic               err_clear,
  output logic               cmd_valid,
  output logic               cmd_push,
  output logic               cmd_pop,
  output logic [7:0]         cmd_data,
  input  logic               cmd_ready,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty,
  output logic               err_overflow,
  output logic               err_underflow,
  output logic               err_dropped
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LVL_FULL = LEVEL_W'(DEPTH);

  // Index 0 is the push input, index 1 is the pop input.
  logic [1:0]       sync1_d, sync1_q;
  logic [1:0]       sync2_d, sync2_q;
  logic [1:0]       stable_d, stable_q;
  logic [CNT_W-1:0] cnt_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [1:0]       ev;

  logic               cmd_valid_d, cmd_valid_q;
  logic               cmd_push_d, cmd_push_q;
  logic               cmd_pop_d, cmd_pop_q;
  logic [7:0]         cmd_data_d, cmd_data_q;
  logic [LEVEL_W-1:0] level_d, level_q;
  logic               err_ovf_d, err_ovf_q;
  logic               err_unf_d, err_unf_q;
  logic               err_drp_d, err_drp_q;

  logic transfer;
  logic busy;
  logic set_ovf, set_unf, set_drp;

  assign sync1_d = {btn_pop_raw, btn_push_raw};
  assign sync2_d = sync1_q;

  // Debounce: the counter runs only while the synchronized input disagrees
  // with the debounced state. It loads the new state on the cycle that
  // would make it reach DEBOUNCE_CYCLES. Only the 0->1 load is an event.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = cnt_q[i];
      ev[i]       = 1'b0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
          ev[i]       = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign transfer = cmd_valid_q & cmd_ready;
  assign busy     = cmd_valid_q & ~cmd_ready;

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_push_d  = cmd_push_q;
    cmd_pop_d   = cmd_pop_q;
    cmd_data_d  = cmd_data_q;
    level_d     = level_q;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;
    set_drp     = 1'b0;

    if (transfer) begin
      cmd_valid_d = 1'b0;
      cmd_push_d  = 1'b0;
      cmd_pop_d   = 1'b0;
      cmd_data_d  = 8'h00;
    end

    // A load may replace a command on the same edge it transfers out.
    if (ev[0]) begin
      if (busy) begin
        set_drp = 1'b1;
      end else if (level_q == LVL_FULL) begin
        set_ovf = 1'b1;
      end else begin
        cmd_valid_d = 1'b1;
        cmd_push_d  = 1'b1;
        cmd_pop_d   = 1'b0;
        cmd_data_d  = data_in;
        level_d     = level_q + LEVEL_W'(1);
      end
    end

    // Push has priority; a pop arriving with it is discarded.
    if (ev[1]) begin
      if (ev[0] || busy) begin
        set_drp = 1'b1;
      end else if (level_q == '0) begin
        set_unf = 1'b1;
      end else begin
        cmd_valid_d = 1'b1;
        cmd_push_d  = 1'b0;
        cmd_pop_d   = 1'b1;
        cmd_data_d  = 8'h00;
        level_d     = level_q - LEVEL_W'(1);
      end
    end

    // Set wins over a coincident clear.
    err_ovf_d = (err_ovf_q & ~err_clear) | set_ovf;
    err_unf_d = (err_unf_q & ~err_clear) | set_unf;
    err_drp_d = (err_drp_q & ~err_clear) | set_drp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_push_q  <= 1'b0;
      cmd_pop_q   <= 1'b0;
      cmd_data_q  <= 8'h00;
      level_q     <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      err_drp_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      cmd_valid_q <= cmd_valid_d;
      cmd_push_q  <= cmd_push_d;
      cmd_pop_q   <= cmd_pop_d;
      cmd_data_q  <= cmd_data_d;
      level_q     <= level_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
      err_drp_q   <= err_drp_d;
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd_push      = cmd_push_q;
  assign cmd_pop       = cmd_pop_q;
  assign cmd_data      = cmd_data_q;
  assign level         = level_q;
  assign full          = (level_q == LVL_FULL);
  assign empty         = (level_q == '0);
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
  assign err_dropped   = err_drp_q;

endmodule

// File: tb/tb_stack_cmd_frontend.sv
// Bench for stack_cmd_frontend, built with DEPTH=2 so full/overflow are
// reachable. It uses a cycle-accurate vector table for the basic flow and
// hand-written sequences for the busy, bounce, overflow, simultaneous-event
// and reset corner cases.
module tb_stack_cmd_frontend;

  localparam int DB = 4;
  localparam int DP = 2;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_push_raw, btn_pop_raw;
  logic [7:0]    data_in;
  logic          err_clear;
  logic          cmd_valid, cmd_push, cmd_pop;
  logic [7:0]    cmd_data;
  logic          cmd_ready;
  logic [LW-1:0] level;
  logic          full, empty;
  logic          err_overflow, err_underflow, err_dropped;

  int n_checks = 0;
  int n_errors = 0;

  stack_cmd_frontend #(.DEBOUNCE_CYCLES(DB), .DEPTH(DP), .LEVEL_W(LW)) dut (
    .clk(clk), .reset(reset),
    .btn_push_raw(btn_push_raw), .btn_pop_raw(btn_pop_raw),
    .data_in(data_in), .err_clear(err_clear),
    .cmd_valid(cmd_valid), .cmd_push(cmd_push), .cmd_pop(cmd_pop),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .level(level), .full(full), .empty(empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_dropped(err_dropped)
  );

  always #5 clk = ~clk;

  // errors packed as {overflow, underflow, dropped}
  typedef struct packed {
    logic       push;
    logic       pop;
    logic [7:0] data;
    logic       rdy;
    logic       clr;
    logic [7:0] ncyc;
    logic       e_valid;
    logic       e_push;
    logic       e_pop;
    logic [7:0] e_data;
    logic [1:0] e_level;
    logic [2:0] e_err;
  } vec_t;

  vec_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_valid(input string nm, input int max_cyc);
    int k;
    k = 0;
    while (cmd_valid !== 1'b1 && k < max_cyc) begin
      tick();
      k++;
    end
    chk({nm, " wait cmd_valid"}, 32'(cmd_valid), 32'd1);
  endtask

  task automatic settle();
    btn_push_raw = 1'b0;
    btn_pop_raw  = 1'b0;
    repeat (12) tick();
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("err_clear", 32'({err_overflow, err_underflow, err_dropped}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncmd;

    //          push pop data   rdy clr n  val psh pop edata  lvl err
    tbl[0]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'b000};
    tbl[1]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 8'hA5, 2'd1, 3'b000};
    tbl[2]  = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1, 3'b000};
    tbl[3]  = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd9, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1, 3'b000};
    tbl[4]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1, 3'b000};
    tbl[5]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 3'b000};
    tbl[6]  = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'b000};
    tbl[7]  = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 8'd9, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'b000};
    // pop at level 0 while err_clear is held: underflow still ends set
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'b010};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'b000};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd9, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'b000};

    reset = 1'b1;
    btn_push_raw = 1'b0;
    btn_pop_raw  = 1'b0;
    data_in      = 8'h00;
    err_clear    = 1'b0;
    cmd_ready    = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("reset level", 32'(level), 32'd0);
    chk("reset empty", 32'(empty), 32'd1);
    chk("reset full", 32'(full), 32'd0);
    chk("reset cmd_valid", 32'(cmd_valid), 32'd0);
    chk("reset errors", 32'({err_overflow, err_underflow, err_dropped}), 32'd0);

    for (int i = 0; i < 11; i++) begin
      btn_push_raw = tbl[i].push;
      btn_pop_raw  = tbl[i].pop;
      data_in      = tbl[i].data;
      cmd_ready    = tbl[i].rdy;
      err_clear    = tbl[i].clr;
      repeat (int'(tbl[i].ncyc)) tick();
      chk($sformatf("vec%0d cmd_valid", i), 32'(cmd_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d cmd_push", i), 32'(cmd_push), 32'(tbl[i].e_push));
        chk($sformatf("vec%0d cmd_pop", i), 32'(cmd_pop), 32'(tbl[i].e_pop));
        chk($sformatf("vec%0d cmd_data", i), 32'(cmd_data), 32'(tbl[i].e_data));
      end
      chk($sformatf("vec%0d level", i), 32'(level), 32'(tbl[i].e_level));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(tbl[i].e_level == 2'd0));
      chk($sformatf("vec%0d errors", i),
          32'({err_overflow, err_underflow, err_dropped}), 32'(tbl[i].e_err));
    end
    err_clear = 1'b0;

    // Stalled command: pop event while busy is dropped, push is held.
    cmd_ready    = 1'b0;
    data_in      = 8'h11;
    btn_push_raw = 1'b1;
    wait_valid("busy push", 10);
    chk("busy level", 32'(level), 32'd1);
    btn_push_raw = 1'b0;
    data_in      = 8'h99;
    btn_pop_raw  = 1'b1;
    repeat (14) tick();
    chk("busy err_dropped", 32'(err_dropped), 32'd1);
    chk("busy cmd_valid held", 32'(cmd_valid), 32'd1);
    chk("busy cmd_push held", 32'(cmd_push), 32'd1);
    chk("busy cmd_data held", 32'(cmd_data), 32'h11);
    chk("busy level held", 32'(level), 32'd1);
    btn_pop_raw = 1'b0;
    cmd_ready   = 1'b1;
    tick();
    chk("busy transfer", 32'(cmd_valid), 32'd0);
    tick();
    chk("busy single transfer", 32'(cmd_valid), 32'd0);
    chk("busy level after", 32'(level), 32'd1);
    settle();
    clear_err();

    // Bouncing push: no command while toggling, exactly one once held.
    data_in = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      btn_push_raw = (i % 2 == 0);
      tick();
      chk($sformatf("bounce%0d no cmd", i), 32'(cmd_valid), 32'd0);
    end
    btn_push_raw = 1'b1;
    ncmd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cmd_valid === 1'b1) begin
        ncmd++;
        chk("bounce cmd_data", 32'(cmd_data), 32'h5A);
      end
    end
    chk("bounce command count", 32'(ncmd), 32'd1);
    chk("bounce level", 32'(level), 32'd2);
    chk("bounce full", 32'(full), 32'd1);
    chk("bounce empty", 32'(empty), 32'd0);
    settle();

    // Push while full is rejected.
    data_in      = 8'h77;
    btn_push_raw = 1'b1;
    repeat (8) tick();
    chk("overflow no cmd", 32'(cmd_valid), 32'd0);
    chk("overflow flag", 32'(err_overflow), 32'd1);
    chk("overflow level", 32'(level), 32'd2);
    settle();
    chk("overflow sticky", 32'(err_overflow), 32'd1);
    clear_err();

    // Pop down to level 1.
    btn_pop_raw = 1'b1;
    wait_valid("pop", 10);
    chk("pop cmd_pop", 32'(cmd_pop), 32'd1);
    chk("pop cmd_data", 32'(cmd_data), 32'd0);
    chk("pop level", 32'(level), 32'd1);
    settle();

    // Simultaneous push+pop: push wins, pop dropped.
    data_in      = 8'hC3;
    btn_push_raw = 1'b1;
    btn_pop_raw  = 1'b1;
    wait_valid("simul", 10);
    chk("simul cmd_push", 32'(cmd_push), 32'd1);
    chk("simul cmd_pop", 32'(cmd_pop), 32'd0);
    chk("simul cmd_data", 32'(cmd_data), 32'hC3);
    chk("simul err_dropped", 32'(err_dropped), 32'd1);
    chk("simul level", 32'(level), 32'd2);
    settle();
    clear_err();

    // Reset during a stalled command aborts it immediately.
    cmd_ready   = 1'b0;
    btn_pop_raw = 1'b1;
    wait_valid("rst pop", 10);
    chk("rst pre level", 32'(level), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst cmd_pop", 32'(cmd_pop), 32'd0);
    chk("rst level", 32'(level), 32'd0);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    btn_pop_raw = 1'b0;
    cmd_ready   = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (12) tick();
    chk("post rst cmd_valid", 32'(cmd_valid), 32'd0);
    chk("post rst level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
